// File: rtl/onewire_master.sv
// 1-Wire bus master: runs one reset/presence, write-bit or read-bit slot per START strobe.
// The pad is open-drain: PAD_I is tied low and only PAD_T toggles between drive-low and release.
module onewire_master #(
    parameter int unsigned CLKS_PER_US = 50
) (
    input  logic       i_c,
    input  logic       i_r,
    input  logic       i_start,
    input  logic [1:0] i_cmd,
    input  logic       i_wbit,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rbit,
    output logic       o_presence,
    output logic       o_pad_i,
    output logic       o_pad_t,
    input  logic       i_pad_o
);

    localparam int unsigned   PW        = $clog2(CLKS_PER_US);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_US - 1);

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StRelease
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_cmd;
    logic          r_wbit;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_us_cnt;
    logic [1:0]    r_sync;
    logic          r_rbit;
    logic          r_presence;
    logic          r_done;

    logic          w_accept;
    logic          w_tick;
    logic          w_bus_s;
    logic [9:0]    w_low_us;
    logic [9:0]    w_samp_us;
    logic [9:0]    w_total_us;
    logic          w_low_end;
    logic          w_samp_hit;
    logic          w_slot_end;

    assign w_accept = (r_state == StIdle) && i_start && (i_cmd != CMD_RSVD);
    assign w_tick   = (r_presc == PRESC_MAX);
    assign w_bus_s  = r_sync[1];

    // Slot profile in microseconds, selected by the latched command.
    always_comb begin
        w_low_us   = 10'd6;
        w_samp_us  = 10'd14;
        w_total_us = 10'd70;
        case (r_cmd)
            CMD_RESET: begin
                w_low_us   = 10'd480;
                w_samp_us  = 10'd550;
                w_total_us = 10'd960;
            end
            CMD_WRITE: begin
                w_low_us   = r_wbit ? 10'd6 : 10'd60;
                w_samp_us  = 10'd0;
                w_total_us = 10'd70;
            end
            default: begin
                w_low_us   = 10'd6;
                w_samp_us  = 10'd14;
                w_total_us = 10'd70;
            end
        endcase
    end

    // Each event fires on the tick that moves us_cnt onto the target value.
    assign w_low_end  = w_tick && (r_us_cnt == w_low_us - 10'd1);
    assign w_samp_hit = w_tick && (r_us_cnt == w_samp_us - 10'd1);
    assign w_slot_end = w_tick && (r_us_cnt == w_total_us - 10'd1);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept)   w_state_next = StLow;
            StLow:     if (w_low_end)  w_state_next = StRelease;
            StRelease: if (w_slot_end) w_state_next = StIdle;
            default:                   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_c) begin
        if (i_r) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_c) begin
        if (i_r) begin
            r_cmd      <= CMD_RESET;
            r_wbit     <= 1'b0;
            r_presc    <= '0;
            r_us_cnt   <= '0;
            r_sync     <= 2'b11;
            r_rbit     <= 1'b0;
            r_presence <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pad_o};
            r_done <= (r_state == StRelease) && w_slot_end;

            if (w_accept) begin
                r_cmd    <= i_cmd;
                r_wbit   <= i_wbit;
                r_presc  <= '0;
                r_us_cnt <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if ((r_state != StIdle) && w_tick) begin
                    r_us_cnt <= r_us_cnt + 10'd1;
                end
            end

            // Sample point always lies in the release phase, so it is reached exactly once.
            if ((r_state == StRelease) && w_samp_hit) begin
                if (r_cmd == CMD_RESET) begin
                    r_presence <= ~w_bus_s;
                end else if (r_cmd == CMD_READ) begin
                    r_rbit <= w_bus_s;
                end
            end
        end
    end

    assign o_busy     = (r_state != StIdle);
    assign o_done     = r_done;
    assign o_rbit     = r_rbit;
    assign o_presence = r_presence;
    assign o_pad_i    = 1'b0;
    assign o_pad_t    = (r_state != StLow);

endmodule
